// File: rtl/shift_pattern_gen.sv
// Multi-mode shift-register pattern generator: ring, Johnson, LFSR, ping-pong.
// Prescaled stepping, parallel load, registered tick/wrap pulses.
module shift_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int PRESC_W = 4,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 'hB8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [PRESC_W-1:0] div,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   out,
  output logic               tick,
  output logic               wrap
);

  typedef enum logic [1:0] {
    M_RING = 2'd0,
    M_JOHN = 2'd1,
    M_LFSR = 2'd2,
    M_PP   = 2'd3
  } mode_e;

  mode_e              mode_q;
  logic [PRESC_W-1:0] presc;
  logic               pp_dir;
  logic [WIDTH-1:0]   nxt;
  logic [WIDTH-1:0]   seed;
  logic               recover;
  logic               pp_nxt;
  logic               step_hit;

  assign step_hit = en && (presc == div);

  always_comb begin
    seed    = (mode_q == M_JOHN) ? '0 : WIDTH'(1);
    recover = (mode_q != M_JOHN) && (out == '0);
    nxt     = out;
    pp_nxt  = pp_dir;
    if (recover) begin
      nxt = WIDTH'(1);
    end else begin
      unique case (mode_q)
        M_RING: nxt = dir ? {out[WIDTH-2:0], out[WIDTH-1]}
                          : {out[0], out[WIDTH-1:1]};
        M_JOHN: nxt = dir ? {out[WIDTH-2:0], ~out[WIDTH-1]}
                          : {~out[0], out[WIDTH-1:1]};
        M_LFSR: nxt = {out[WIDTH-2:0], ^(out & LFSR_TAPS)};
        M_PP:   nxt = pp_dir ? {out[WIDTH-2:0], 1'b0}
                             : {1'b0, out[WIDTH-1:1]};
        default: nxt = out;
      endcase
    end
    // bounce when the pattern reaches the far end
    if (mode_q == M_PP) begin
      if (pp_dir && nxt[WIDTH-1]) begin
        pp_nxt = 1'b0;
      end else if (!pp_dir && nxt[0]) begin
        pp_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out    <= '0;
      presc  <= '0;
      mode_q <= M_RING;
      pp_dir <= 1'b1;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (mode != mode_q) begin
        mode_q <= mode_e'(mode);
        out    <= '0;
        presc  <= '0;
        pp_dir <= 1'b1;
      end else if (load) begin
        out   <= load_val;
        presc <= '0;
      end else if (step_hit) begin
        out    <= nxt;
        presc  <= '0;
        pp_dir <= pp_nxt;
        tick   <= 1'b1;
        wrap   <= !recover && (nxt == seed);
      end else if (en) begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: doc/shift_pattern_gen.md
Name: shift_pattern_gen

Overview:
Parametrised multi-mode shift-register pattern generator for LED/output banks. It generalises the fixed 8-bit Johnson counter to WIDTH bits with four patterns: ring, Johnson, LFSR and ping-pong. It adds direction control, a programmable step prescaler, parallel load and status pulses. It drives an LED bank directly or feeds a display/test-pattern path.

Parameters:
WIDTH, 8, pattern register width (>=3)
PRESC_W, 4, prescaler counter width
LFSR_TAPS, 8'hB8, Fibonacci feedback mask (WIDTH bits); default is maximal-length for WIDTH=8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
en  in  1  step enable; 0 freezes prescaler and pattern
mode  in  2  0=ring, 1=Johnson, 2=LFSR, 3=ping-pong
dir  in  1  0=shift right (toward bit 0), 1=shift left; ignored in modes 2 and 3
div  in  PRESC_W  step every div+1 enabled cycles
load  in  1  parallel load strobe
load_val  in  WIDTH  value loaded on load
out  out  WIDTH  current pattern register
tick  out  1  1-cycle pulse on every pattern step
wrap  out  1  1-cycle pulse on a step that returns the pattern to its mode seed

Behaviour:
- Reset (rst=0, async): out=0, prescaler=0, mode_q=0, pp_dir=left, tick=0, wrap=0.
- Per-clock priority: mode change > load > step > hold.
- Mode change: if mode != mode_q, then mode_q<=mode, out<=0, prescaler<=0, pp_dir<=left, no tick.
- Load: if load=1 and no mode change, then out<=load_val, prescaler<=0, no tick. Load is honoured even when en=0.
- Prescaler: while en=1, count 0..div. Step fires in the cycle where count==div; count then returns to 0. div=0 gives a step every cycle. A div change takes effect at the next compare.
- tick and wrap are registered: they assert in the same cycle the new out value is visible.
- Seeds: Johnson=0; ring, LFSR and ping-pong=1 (bit 0 set).
- Zero recovery: a step in modes 0/2/3 with out==0 loads seed 1. wrap does not assert on this recovery step.
- Step rules (r = out):
  - Ring: dir=0 gives {r[0], r[W-1:1]}; dir=1 gives {r[W-2:0], r[W-1]}.
  - Johnson: dir=0 gives {~r[0], r[W-1:1]}; dir=1 gives {r[W-2:0], ~r[W-1]}. Period 2*WIDTH.
  - LFSR: {r[W-2:0], ^(r & LFSR_TAPS)}. Period 2^WIDTH-1 for maximal taps.
  - Ping-pong: shift one place per pp_dir.
    - pp_dir flips to right in the step that sets bit W-1.
    - pp_dir flips to left in the step that sets bit 0.
    - Period 2*(WIDTH-1).
    - A non-one-hot loaded value shifts as-is; any bit leaving the register is lost. Zero recovery then applies.
- wrap: asserts on a non-recovery step whose result equals the mode seed.
- A dir change takes effect on the next step. Pattern state is preserved across the dir change.
- Reset asserted mid-operation forces all reset values immediately. First step after release follows the prescaler count from 0.

Test Plan:
- Johnson, WIDTH=8, div=0, dir=0, en=1 after reset -> out sequence 00,80,C0,E0,F0,F8,FC,FE,FF,7F,3F,1F,0F,07,03,01,00; wrap only on the 16th step; tick every cycle.
- Ring dir=0 from reset -> step1 01 (recovery, wrap=0), step2 80, step3 40, ... step9 01 with wrap=1. Switch dir=1 at out=20 -> next 40.
- LFSR from reset -> 01,02,04,08,11 (step 5). After 255 non-recovery steps out returns to 01 with wrap=1. All 255 values are distinct.
- Prescaler div=3, en toggled low for 2 cycles mid-count -> tick every 4 enabled cycles; count frozen while en=0.
- Ping-pong -> 01,02,...,80,40,...,01; wrap on the 14th step after seed. Load 0x18 with load=1 and en=0 -> out=18, no tick.
- Mode change Johnson->ring when out=F0 while load=1 in the same cycle -> out=00 (mode change wins), next step 01. Async rst mid-count -> out=00 immediately with no clock edge.
